// File: rtl/wb_sel_pkg.sv
// Shared definitions for the Wishbone slave selector: FSM encoding,
// slave index constants, default read data and timeout counter width.
package wb_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

    localparam int NUM_SLV = 3;

    localparam logic [1:0] IDX_REG   = 2'd0;
    localparam logic [1:0] IDX_UART0 = 2'd1;
    localparam logic [1:0] IDX_UART1 = 2'd2;

    localparam logic [31:0] DEF_DATA = 32'hFABDEFAC;

    localparam int CNT_W = 8;

endpackage

// File: rtl/wb_ack_timer.sv
// Free-running wait counter for one slave access. Cleared while the
// selector is not waiting, counts each waiting cycle, and flags the
// last cycle the selector is willing to wait for an ack.
module wb_ack_timer #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 255
) (
    input  logic WBs_CLK_i,
    input  logic WBs_RSTn_i,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q;

    // Wait-cycle counter: reset/clear dominate, otherwise count while enabled.
    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RSTn_i || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wb_slave_sel_ctrl.sv
// Wishbone slave selector between the AHB-to-FPGA bridge and three FPGA
// slaves (register file, UART0, UART1). Decodes the top two address bits,
// strobes the chosen slave, waits for its ack (or times out) and returns
// registered read data plus a one-cycle ack to the bridge.
//
// Handshake: the bridge raises CYC and STB together; a request is taken
// when both are seen high in IDLE. CYC must stay high until WBs_ACK_o has
// pulsed; dropping CYC while waiting abandons the access with no ack. A
// slave responds only while its slv_cyc_o bit is high, and its ack is
// honoured only in that window.
module wb_slave_sel_ctrl
    import wb_sel_pkg::*;
#(
    parameter int                   ADDRWIDTH     = 17,
    parameter int                   DATAWIDTH     = 32,
    parameter logic [1:0]           SEL_REG       = 2'b00,
    parameter logic [1:0]           SEL_UART0     = 2'b01,
    parameter logic [1:0]           SEL_UART1     = 2'b10,
    parameter int                   TIMEOUT_CYC   = 255,
    parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE = DEF_DATA
) (
    input  logic                           WBs_CLK_i,
    input  logic                           WBs_RSTn_i,
    input  logic [ADDRWIDTH-1:0]           WBs_ADR_i,
    input  logic                           WBs_CYC_i,
    input  logic                           WBs_STB_i,
    input  logic                           WBs_WE_i,
    input  logic [3:0]                     WBs_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0]           WBs_DAT_i,
    output logic [DATAWIDTH-1:0]           WBs_DAT_o,
    output logic                           WBs_ACK_o,
    output logic [NUM_SLV-1:0]             slv_cyc_o,
    input  logic [NUM_SLV*DATAWIDTH-1:0]   slv_dat_i,
    input  logic [NUM_SLV-1:0]             slv_ack_i,
    input  logic                           tmo_clr_i,
    output logic                           tmo_flag_o,
    output logic [ADDRWIDTH-1:0]           tmo_adr_o,
    output logic [1:0]                     dbg_state_o
);

    wb_state_e              state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [DATAWIDTH-1:0]   rdata_q, rdata_d;
    logic                   tmo_flag_d;
    logic [ADDRWIDTH-1:0]   tmo_adr_d;

    logic [1:0]             adr_sel;
    logic                   dec_mapped;
    logic [1:0]             dec_idx;
    logic                   sel_ack;
    logic [DATAWIDTH-1:0]   sel_dat;
    logic                   tmr_expire;

    // Write data, write enable and byte strobes reach the slaves straight
    // from the bridge; the selector itself never looks at them.
    logic unused_ok;
    assign unused_ok = ^{WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i};

    assign adr_sel     = WBs_ADR_i[ADDRWIDTH-1 -: 2];
    assign dbg_state_o = state_q;

    wb_ack_timer #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_ack_timer (
        .WBs_CLK_i  (WBs_CLK_i),
        .WBs_RSTn_i (WBs_RSTn_i),
        .clr        (state_q != ST_BUSY),
        .en         (state_q == ST_BUSY),
        .expire     (tmr_expire)
    );

    // Address decode: top two address bits pick a slave; the fourth code is unmapped.
    always_comb begin
        dec_mapped = 1'b1;
        dec_idx    = IDX_REG;
        case (adr_sel)
            SEL_REG:   dec_idx = IDX_REG;
            SEL_UART0: dec_idx = IDX_UART0;
            SEL_UART1: dec_idx = IDX_UART1;
            default:   dec_mapped = 1'b0;
        endcase
    end

    // Latched-slave muxing: ack/data from the selected slave, strobe only while waiting.
    always_comb begin
        sel_ack   = 1'b0;
        sel_dat   = '0;
        slv_cyc_o = '0;
        case (idx_q)
            IDX_REG: begin
                sel_ack      = slv_ack_i[0];
                sel_dat      = slv_dat_i[0*DATAWIDTH +: DATAWIDTH];
                slv_cyc_o[0] = (state_q == ST_BUSY);
            end
            IDX_UART0: begin
                sel_ack      = slv_ack_i[1];
                sel_dat      = slv_dat_i[1*DATAWIDTH +: DATAWIDTH];
                slv_cyc_o[1] = (state_q == ST_BUSY);
            end
            IDX_UART1: begin
                sel_ack      = slv_ack_i[2];
                sel_dat      = slv_dat_i[2*DATAWIDTH +: DATAWIDTH];
                slv_cyc_o[2] = (state_q == ST_BUSY);
            end
            default: begin
                sel_ack = 1'b0;
            end
        endcase
    end

    // Next-state logic: request decode, ack/timeout/abort handling, sticky timeout flag.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rdata_d    = rdata_q;
        tmo_flag_d = tmo_flag_o & ~tmo_clr_i;
        tmo_adr_d  = tmo_adr_o;
        case (state_q)
            ST_IDLE: begin
                if (WBs_CYC_i && WBs_STB_i) begin
                    if (dec_mapped) begin
                        idx_d   = dec_idx;
                        state_d = ST_BUSY;
                    end else begin
                        rdata_d = DEF_REG_VALUE;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (!WBs_CYC_i) begin
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    // A late ack in the final wait cycle still beats the timeout.
                    rdata_d = sel_dat;
                    state_d = ST_DONE;
                end else if (tmr_expire) begin
                    // Setting the flag overrides a clear arriving in the same cycle.
                    rdata_d    = DEF_REG_VALUE;
                    tmo_flag_d = 1'b1;
                    tmo_adr_d  = WBs_ADR_i;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; the bridge ack/data are launched from DONE.
    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RSTn_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= IDX_REG;
            rdata_q    <= '0;
            WBs_ACK_o  <= 1'b0;
            WBs_DAT_o  <= '0;
            tmo_flag_o <= 1'b0;
            tmo_adr_o  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rdata_q    <= rdata_d;
            WBs_ACK_o  <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                WBs_DAT_o <= rdata_q;
            end
            tmo_flag_o <= tmo_flag_d;
            tmo_adr_o  <= tmo_adr_d;
        end
    end

endmodule

// File: tb/tb_wb_slave_sel_ctrl.sv
// Bench for the Wishbone slave selector. The bridge side is driven by
// tasks, slaves are emulated cycle by cycle, and every access is judged
// against a transaction-level model of the selector's rules.
module tb_wb_slave_sel_ctrl;

  localparam int AW = 17;
  localparam int DW = 32;
  localparam int TMO = 255;
  localparam logic [31:0] DEF = 32'hFABDEFAC;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [AW-1:0] WBs_ADR_i = '0;
  logic WBs_CYC_i = 1'b0;
  logic WBs_STB_i = 1'b0;
  logic WBs_WE_i = 1'b0;
  logic [3:0] WBs_BYTE_STB_i = '0;
  logic [DW-1:0] WBs_DAT_i = '0;
  logic [DW-1:0] WBs_DAT_o;
  logic WBs_ACK_o;
  logic [2:0] slv_cyc_o;
  logic [3*DW-1:0] slv_dat_i = '0;
  logic [2:0] slv_ack_i = '0;
  logic tmo_clr_i = 1'b0;
  logic tmo_flag_o;
  logic [AW-1:0] tmo_adr_o;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass = 0;

  // reference model state for the sticky timeout capture
  logic m_flag = 1'b0;
  logic [AW-1:0] m_adr = '0;

  typedef struct {
    int lat;
    logic [31:0] dat;
    int cyc_cnt;
    logic [2:0] cyc_or;
    bit tmo;
  } exp_t;

  // clock / reset block
  always #5 clk = ~clk;

  wb_slave_sel_ctrl dut (
    .WBs_CLK_i      (clk),
    .WBs_RSTn_i     (rstn),
    .WBs_ADR_i      (WBs_ADR_i),
    .WBs_CYC_i      (WBs_CYC_i),
    .WBs_STB_i      (WBs_STB_i),
    .WBs_WE_i       (WBs_WE_i),
    .WBs_BYTE_STB_i (WBs_BYTE_STB_i),
    .WBs_DAT_i      (WBs_DAT_i),
    .WBs_DAT_o      (WBs_DAT_o),
    .WBs_ACK_o      (WBs_ACK_o),
    .slv_cyc_o      (slv_cyc_o),
    .slv_dat_i      (slv_dat_i),
    .slv_ack_i      (slv_ack_i),
    .tmo_clr_i      (tmo_clr_i),
    .tmo_flag_o     (tmo_flag_o),
    .tmo_adr_o      (tmo_adr_o),
    .dbg_state_o    (dbg_state)
  );

  // Transaction-level model. ack_at is the strobe cycle (1-based) in which
  // the slave acks, 0 meaning never. Latency counts clock edges from the
  // edge that samples the request to the edge that raises the bridge ack.
  function automatic exp_t model_txn(input logic [AW-1:0] adr, input int ack_at, input logic [31:0] sdat);
    exp_t e;
    int sel;
    sel = int'(adr[AW-1 -: 2]);
    if (sel == 3) begin
      e.lat = 1; e.dat = DEF; e.cyc_cnt = 0; e.cyc_or = 3'b000; e.tmo = 0;
    end else if (ack_at >= 1 && ack_at <= TMO) begin
      e.lat = ack_at + 1; e.dat = sdat; e.cyc_cnt = ack_at; e.cyc_or = 3'(1 << sel); e.tmo = 0;
    end else begin
      e.lat = TMO + 1; e.dat = DEF; e.cyc_cnt = TMO; e.cyc_or = 3'(1 << sel); e.tmo = 1;
    end
    return e;
  endfunction

  // Sticky flag rule: a clear inside the strobe window drops it, a timeout sets it last.
  function automatic void model_flag(input exp_t e, input logic [AW-1:0] adr, input int clr_at);
    if (clr_at >= 1 && clr_at <= e.cyc_cnt) m_flag = 1'b0;
    if (e.tmo) begin
      m_flag = 1'b1;
      m_adr = adr;
    end
  endfunction

  // Driver: one bridge access plus emulated slaves; STB for one sample, CYC until ack.
  task automatic drive_txn(input logic [AW-1:0] adr, input logic we, input logic [31:0] sdat,
                           input int ack_at, input bit noise, input int clr_at,
                           output int lat, output logic [31:0] dat, output int cyc_cnt,
                           output logic [2:0] cyc_or, output bit pulse_ok);
    int tgt;
    int busy;
    tgt = int'(adr[AW-1 -: 2]);
    @(negedge clk);
    WBs_ADR_i = adr;
    WBs_WE_i = we;
    WBs_BYTE_STB_i = 4'($urandom_range(0, 15));
    WBs_DAT_i = $urandom;
    for (int s = 0; s < 3; s++) slv_dat_i[s*32 +: 32] = (s == tgt) ? sdat : $urandom;
    WBs_CYC_i = 1'b1;
    WBs_STB_i = 1'b1;
    @(posedge clk);
    #1;
    WBs_STB_i = 1'b0;
    lat = -1; dat = '0; cyc_cnt = 0; cyc_or = '0; busy = 0; pulse_ok = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      slv_ack_i = '0;
      tmo_clr_i = 1'b0;
      if (WBs_ACK_o) begin
        lat = c - 1;
        dat = WBs_DAT_o;
        break;
      end
      cyc_or |= slv_cyc_o;
      if (slv_cyc_o != 3'b000) cyc_cnt++;
      if (tgt < 3 && slv_cyc_o[tgt]) begin
        busy++;
        if (busy == ack_at) slv_ack_i[tgt] = 1'b1;
        if (busy == clr_at) tmo_clr_i = 1'b1;
      end
      if (noise) begin
        for (int s = 0; s < 3; s++)
          if ((s != tgt || !slv_cyc_o[s]) && $urandom_range(0, 1) == 1) slv_ack_i[s] = 1'b1;
      end
    end
    @(negedge clk);
    pulse_ok = (lat >= 0) && !WBs_ACK_o;
    WBs_CYC_i = 1'b0;
    slv_ack_i = '0;
    tmo_clr_i = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    tmo_clr_i = 1'b1;
    @(posedge clk);
    #1;
    tmo_clr_i = 1'b0;
    m_flag = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (WBs_ACK_o !== 1'b0) $display("FAIL reset_ack got %b exp 0", WBs_ACK_o); else n_pass++;
    n_checks++; if (WBs_DAT_o !== 32'h0) $display("FAIL reset_dat got %h exp 0", WBs_DAT_o); else n_pass++;
    n_checks++; if (slv_cyc_o !== 3'b000) $display("FAIL reset_cyc got %b exp 000", slv_cyc_o); else n_pass++;
    n_checks++; if (tmo_flag_o !== 1'b0) $display("FAIL reset_flag got %b exp 0", tmo_flag_o); else n_pass++;
    n_checks++; if (tmo_adr_o !== '0) $display("FAIL reset_tmo_adr got %h exp 0", tmo_adr_o); else n_pass++;
    rstn = 1'b1;
    m_flag = 1'b0;
    m_adr = '0;
  endtask

  task automatic test_reg_read();
    int lat, cc; logic [31:0] d; logic [2:0] co; bit p; exp_t e;
    e = model_txn(17'h00000, 1, 32'hABCD0002);
    drive_txn(17'h00000, 1'b0, 32'hABCD0002, 1, 0, 0, lat, d, cc, co, p);
    model_flag(e, 17'h00000, 0);
    n_checks++; if (lat !== e.lat) $display("FAIL reg_read_lat got %0d exp %0d", lat, e.lat); else n_pass++;
    n_checks++; if (d !== e.dat) $display("FAIL reg_read_dat got %h exp %h", d, e.dat); else n_pass++;
    n_checks++; if (co !== e.cyc_or || cc !== e.cyc_cnt) $display("FAIL reg_read_cyc got %b/%0d exp %b/%0d", co, cc, e.cyc_or, e.cyc_cnt); else n_pass++;
    n_checks++; if (!p) $display("FAIL reg_read_pulse got ack held exp single cycle"); else n_pass++;
  endtask

  task automatic test_uart1_write();
    int lat, cc; logic [31:0] d, sd; logic [2:0] co; bit p; exp_t e; logic [AW-1:0] a;
    a = 17'h10000 | 17'($urandom_range(0, 17'h7FFF));
    sd = $urandom;
    e = model_txn(a, 5, sd);
    drive_txn(a, 1'b1, sd, 5, 0, 0, lat, d, cc, co, p);
    model_flag(e, a, 0);
    n_checks++; if (co !== 3'b100 || cc !== 5) $display("FAIL uart1_cyc got %b/%0d exp 100/5", co, cc); else n_pass++;
    n_checks++; if (lat !== e.lat) $display("FAIL uart1_lat got %0d exp %0d", lat, e.lat); else n_pass++;
    n_checks++; if (!p) $display("FAIL uart1_pulse got ack held exp single cycle"); else n_pass++;
    n_checks++; if (tmo_flag_o !== 1'b0) $display("FAIL uart1_flag got %b exp 0", tmo_flag_o); else n_pass++;
  endtask

  task automatic test_unmapped();
    int lat, cc; logic [31:0] d; logic [2:0] co; bit p; exp_t e; logic [AW-1:0] a;
    a = 17'h18000 | 17'($urandom_range(0, 17'h7FFF));
    e = model_txn(a, 1, 32'h12345678);
    drive_txn(a, 1'b0, 32'h12345678, 1, 0, 0, lat, d, cc, co, p);
    model_flag(e, a, 0);
    n_checks++; if (lat !== 1) $display("FAIL unmapped_lat got %0d exp 1", lat); else n_pass++;
    n_checks++; if (d !== DEF) $display("FAIL unmapped_dat got %h exp %h", d, DEF); else n_pass++;
    n_checks++; if (co !== 3'b000) $display("FAIL unmapped_cyc got %b exp 000", co); else n_pass++;
  endtask

  task automatic test_timeout();
    int lat, cc; logic [31:0] d; logic [2:0] co; bit p; exp_t e; logic [AW-1:0] a;
    a = 17'h08000 | 17'($urandom_range(0, 17'h7FFF));
    e = model_txn(a, 0, 32'h0);
    drive_txn(a, 1'b0, 32'h5555AAAA, 0, 0, 0, lat, d, cc, co, p);
    model_flag(e, a, 0);
    n_checks++; if (lat !== TMO + 1) $display("FAIL timeout_lat got %0d exp %0d", lat, TMO + 1); else n_pass++;
    n_checks++; if (d !== DEF) $display("FAIL timeout_dat got %h exp %h", d, DEF); else n_pass++;
    n_checks++; if (cc !== TMO || co !== 3'b010) $display("FAIL timeout_cyc got %b/%0d exp 010/%0d", co, cc, TMO); else n_pass++;
    n_checks++; if (tmo_flag_o !== m_flag) $display("FAIL timeout_flag got %b exp %b", tmo_flag_o, m_flag); else n_pass++;
    n_checks++; if (tmo_adr_o !== m_adr) $display("FAIL timeout_adr got %h exp %h", tmo_adr_o, m_adr); else n_pass++;
    pulse_clear();
    @(negedge clk);
    n_checks++; if (tmo_flag_o !== 1'b0) $display("FAIL timeout_clr got %b exp 0", tmo_flag_o); else n_pass++;
    // clear asserted in the expiring cycle: the new timeout must win
    a = 17'h00000 | 17'($urandom_range(0, 17'h7FFF));
    e = model_txn(a, 0, 32'h0);
    drive_txn(a, 1'b0, 32'h0, 0, 0, TMO, lat, d, cc, co, p);
    model_flag(e, a, TMO);
    n_checks++; if (tmo_flag_o !== 1'b1) $display("FAIL set_beats_clr got %b exp 1", tmo_flag_o); else n_pass++;
    n_checks++; if (tmo_adr_o !== a) $display("FAIL set_beats_clr_adr got %h exp %h", tmo_adr_o, a); else n_pass++;
    pulse_clear();
  endtask

  task automatic test_ack_at_timeout();
    int lat, cc; logic [31:0] d, sd; logic [2:0] co; bit p; exp_t e; logic [AW-1:0] a;
    a = 17'h08000 | 17'($urandom_range(0, 17'h7FFF));
    sd = $urandom;
    e = model_txn(a, TMO, sd);
    drive_txn(a, 1'b0, sd, TMO, 0, 0, lat, d, cc, co, p);
    model_flag(e, a, 0);
    n_checks++; if (d !== sd) $display("FAIL ack_vs_tmo_dat got %h exp %h", d, sd); else n_pass++;
    n_checks++; if (lat !== e.lat) $display("FAIL ack_vs_tmo_lat got %0d exp %0d", lat, e.lat); else n_pass++;
    n_checks++; if (tmo_flag_o !== 1'b0) $display("FAIL ack_vs_tmo_flag got %b exp 0", tmo_flag_o); else n_pass++;
  endtask

  task automatic test_wrong_ack();
    int lat, cc; logic [31:0] d, sd; logic [2:0] co; bit p; exp_t e;
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] a;
      a = {2'(i), 15'($urandom_range(0, 17'h7FFF))};
      sd = $urandom;
      e = model_txn(a, 4, sd);
      drive_txn(a, 1'b0, sd, 4, 1, 0, lat, d, cc, co, p);
      model_flag(e, a, 0);
      n_checks++; if (lat !== e.lat || d !== e.dat) $display("FAIL wrong_ack_%0d got %0d/%h exp %0d/%h", i, lat, d, e.lat, e.dat); else n_pass++;
    end
  endtask

  task automatic test_abort();
    bit seen_ack;
    @(negedge clk);
    WBs_ADR_i = 17'h08000;
    WBs_CYC_i = 1'b1;
    WBs_STB_i = 1'b1;
    @(posedge clk);
    #1;
    WBs_STB_i = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (slv_cyc_o !== 3'b010) $display("FAIL abort_busy_cyc got %b exp 010", slv_cyc_o); else n_pass++;
    WBs_CYC_i = 1'b0;
    @(negedge clk);
    n_checks++; if (slv_cyc_o !== 3'b000) $display("FAIL abort_cyc got %b exp 000", slv_cyc_o); else n_pass++;
    seen_ack = 0;
    repeat (6) begin
      @(negedge clk);
      if (WBs_ACK_o) seen_ack = 1;
    end
    n_checks++; if (seen_ack) $display("FAIL abort_ack got ack exp none"); else n_pass++;
    n_checks++; if (tmo_flag_o !== m_flag) $display("FAIL abort_flag got %b exp %b", tmo_flag_o, m_flag); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, cc; logic [31:0] d, sd; logic [2:0] co; bit p; exp_t e;
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] a;
      a = {2'(i), 15'($urandom_range(0, 17'h7FFF))};
      sd = $urandom;
      e = model_txn(a, 1, sd);
      drive_txn(a, 1'b0, sd, 1, 0, 0, lat, d, cc, co, p);
      model_flag(e, a, 0);
      n_checks++; if (lat !== e.lat || d !== e.dat || co !== e.cyc_or) $display("FAIL b2b_%0d got %0d/%h/%b exp %0d/%h/%b", i, lat, d, co, e.lat, e.dat, e.cyc_or); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int lat, cc; logic [31:0] d; logic [2:0] co; bit p; exp_t e;
    e = model_txn(17'h10000, 0, 32'h0);
    drive_txn(17'h10000, 1'b0, 32'h0, 0, 0, 0, lat, d, cc, co, p);
    model_flag(e, 17'h10000, 0);
    n_checks++; if (tmo_flag_o !== 1'b1) $display("FAIL pre_reset_flag got %b exp 1", tmo_flag_o); else n_pass++;
    @(negedge clk);
    WBs_ADR_i = 17'h00000;
    WBs_CYC_i = 1'b1;
    WBs_STB_i = 1'b1;
    @(posedge clk);
    #1;
    WBs_STB_i = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    n_checks++; if (slv_cyc_o !== 3'b000) $display("FAIL mid_reset_cyc got %b exp 000", slv_cyc_o); else n_pass++;
    n_checks++; if (tmo_flag_o !== 1'b0 || tmo_adr_o !== '0) $display("FAIL mid_reset_tmo got %b/%h exp 0/0", tmo_flag_o, tmo_adr_o); else n_pass++;
    n_checks++; if (WBs_ACK_o !== 1'b0 || WBs_DAT_o !== 32'h0) $display("FAIL mid_reset_bus got %b/%h exp 0/0", WBs_ACK_o, WBs_DAT_o); else n_pass++;
    WBs_CYC_i = 1'b0;
    rstn = 1'b1;
    m_flag = 1'b0;
    m_adr = '0;
  endtask

  task automatic test_random();
    int lat, cc, ack_at, clr_at; logic [31:0] d, sd; logic [2:0] co; bit p, noise; exp_t e;
    logic [AW-1:0] a;
    for (int i = 0; i < 16; i++) begin
      a = 17'($urandom_range(0, 17'h1FFFF));
      sd = $urandom;
      ack_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      clr_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      noise = 1'($urandom_range(0, 1));
      e = model_txn(a, ack_at, sd);
      drive_txn(a, 1'($urandom_range(0, 1)), sd, ack_at, noise, clr_at, lat, d, cc, co, p);
      model_flag(e, a, clr_at);
      n_checks++; if (lat !== e.lat || d !== e.dat) $display("FAIL rand_%0d_resp got %0d/%h exp %0d/%h", i, lat, d, e.lat, e.dat); else n_pass++;
      n_checks++; if (co !== e.cyc_or || cc !== e.cyc_cnt) $display("FAIL rand_%0d_cyc got %b/%0d exp %b/%0d", i, co, cc, e.cyc_or, e.cyc_cnt); else n_pass++;
      n_checks++; if (tmo_flag_o !== m_flag || tmo_adr_o !== m_adr) $display("FAIL rand_%0d_tmo got %b/%h exp %b/%h", i, tmo_flag_o, tmo_adr_o, m_flag, m_adr); else n_pass++;
      n_checks++; if (!p) $display("FAIL rand_%0d_pulse got ack held exp single cycle", i); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_reg_read();
    test_uart1_write();
    test_unmapped();
    test_timeout();
    test_ack_at_timeout();
    test_wrong_ack();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
